// File: rtl/fp_div_issue_ctrl.sv
// Issue/collect stage for the FP32 iterative divider: queues tagged operand pairs,
// launches one at a time, and returns each result (or a timeout) with its tag in order.
module fp_div_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      div_A,
    output logic [31:0]      div_B,
    output logic             div_En,
    input  logic [31:0]      div_Result,
    input  logic             div_Ready,
    input  logic             div_NaN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_nan,
    output logic             out_timeout,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [31:0]      mem_a   [DEPTH];
    logic [31:0]      mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [1:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [TAG_W-1:0] cur_tag;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == S_ISSUE);
    assign div_En   = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Operands are latched on the IDLE->ISSUE edge so they are already stable
    // on div_A/div_B while div_En is high; the head is popped at the end of ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            div_A       <= '0;
            div_B       <= '0;
            cur_tag     <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_nan     <= 1'b0;
            out_timeout <= 1'b0;
            out_tag     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty && !out_valid) begin
                        state   <= S_ISSUE;
                        div_A   <= mem_a[rd_ptr];
                        div_B   <= mem_b[rd_ptr];
                        cur_tag <= mem_tag[rd_ptr];
                    end
                end
                S_ISSUE: begin
                    state   <= S_WAIT;
                    tmo_cnt <= '0;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (div_NaN || div_Ready) begin
                        state       <= S_RESP;
                        out_valid   <= 1'b1;
                        out_result  <= div_Result;
                        out_nan     <= div_NaN;
                        out_timeout <= 1'b0;
                        out_tag     <= cur_tag;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state       <= S_RESP;
                        out_valid   <= 1'b1;
                        out_result  <= QNAN;
                        out_nan     <= 1'b0;
                        out_timeout <= 1'b1;
                        out_tag     <= cur_tag;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        tmo_cnt   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
